multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle FSM control unit for the RV32I datapath; successor to the single-cycle combinational decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a ready handshake.
//  Drives all datapath strobes (ALUOp as alu_op_t from alu_op_pkg) and flags illegal instructions and memory timeouts.
//  Keeps a retired-instruction counter.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles for mem_ready per access; 0 = never time out
//  INSTRET_W    32  width of retired-instruction counter (wraps modulo 2^INSTRET_W)
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          reset; asynchronous, active-low
//  instr      in   32         instruction register contents (valid from DECODE onward)
//  mem_ready  in   1          memory completed current request this cycle
//  mem_req    out  1          memory request active (fetch or data)
//  IorD       out  1          0 = instruction address (PC), 1 = data address (ALU result)
//  IRWrite    out  1          load instr register from memory read data
//  PCWrite    out  1          PC <= PC+4
//  Branch     out  1          PC <= target if ALU Zero (one-cycle pulse)
//  MemRead    out  1          memory read
//  MemWrite   out  1          memory write
//  MemtoReg   out  1          writeback source: 1 = memory data, 0 = ALU result
//  ALUSrc     out  1          ALU B operand: 1 = immediate, 0 = rs2
//  ALUOp      out  4          alu_op_t operation
//  RegWrite   out  1          register file write enable (one-cycle pulse)
//  illegal    out  1          sticky: illegal instruction decoded
//  bus_err    out  1          sticky: memory timeout
//  state      out  3          FSM state for debug
//  instret    out  INSTRET_W  retired-instruction count
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, instret=0, illegal=0, bus_err=0, wait counter=0, decode latches=0.
//  Reset is honoured mid-operation in any state; no strobe glitches above 0 during reset.
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 go to TRAP.
//  Every output not listed for a state is 0 (never X); ALUOp defaults to ADD.
//  FETCH:  mem_req=1, MemRead=1, IorD=0.
//          On mem_ready: IRWrite=1 and PCWrite=1 in that same cycle, then go to DECODE.
//  DECODE: classify instr[6:0] into LOAD 0000011, STORE 0100011, BRANCH 1100011, OP 0110011, OP-IMM 0010011.
//          Latch class and ALUOp. Any other opcode -> TRAP with illegal=1.
//          OP: funct7 must be 00, or 20 only with funct3 000/101; otherwise illegal.
//          OP-IMM shifts: funct3 001 needs funct7=00; funct3 101 needs funct7 00/20; otherwise illegal.
//  ALUOp map: funct3 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
//          SUB only for OP with funct7=20; OP-IMM funct3=000 is always ADD.
//          LOAD/STORE use ADD; BRANCH uses SUB.
//  EXEC:   ALUOp driven; ALUSrc=1 for LOAD/STORE/OP-IMM, 0 for OP/BRANCH.
//          BRANCH: Branch=1 for one cycle, retire, go to FETCH.
//          LOAD/STORE -> MEM; OP/OP-IMM -> WB.
//  MEM:    mem_req=1, IorD=1, ALUSrc=1, ALUOp=ADD; MemRead=1 for LOAD, MemWrite=1 for STORE.
//          Strobes hold until mem_ready.
//          On mem_ready: LOAD -> WB; STORE -> retire, go to FETCH.
//  WB:     RegWrite=1, MemtoReg=1 if LOAD else 0; retire, go to FETCH.
//  TRAP:   all strobes 0; stays until reset; illegal/bus_err remain set.
//  Wait counter: counts cycles in FETCH/MEM with mem_ready=0; cleared on state change.
//          When it reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP, bus_err=1.
//          If mem_ready=1 in the same cycle as the timeout, ready wins and there is no error.
//  mem_ready outside FETCH/MEM: ignored.
//  Retire: instret += 1 on leaving WB, on STORE completion in MEM, and on BRANCH in EXEC. Wraps to 0.
//  Latency with mem_ready always 1: OP = 4 cycles, BRANCH = 3, STORE = 4, LOAD = 5.
// TESTING
//  1 add x1,x2,x3 (0x003100B3), mem_ready=1 -> states 0,1,2,4,0.
//    ALUOp=ADD, ALUSrc=0, one RegWrite pulse; instret 0->1 after 4 cycles.
//  2 sub 0x403100B3 then sra 0x403150B3 -> ALUOp SUB then SRA.
//    addi 0x00510093 -> ADD with ALUSrc=1 in EXEC.
//  3 lw 0x0000A083, mem_ready low 3 cycles in MEM -> MemRead/IorD held 3 cycles.
//    Then WB with MemtoReg=1, RegWrite=1; total 8 cycles.
//  4 MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> TRAP after 4 wait cycles, bus_err=1.
//    Repeat with mem_ready on the 4th cycle -> DECODE, bus_err=0.
//  5 opcode 0x7F, or OP with funct7=0x01 -> TRAP, illegal=1, all strobes 0.
//    Stays in TRAP; rst_n pulse -> FETCH, flags cleared.
//  6 INSTRET_W=4, 16 branches -> instret wraps 15->0.
//    rst_n asserted mid-MEM of a store -> MemWrite drops immediately; no retire.

Source files
------------

// File: rtl/alu_op_pkg.sv
// ALU operation encoding shared by the control unit and the datapath ALU.
package alu_op_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } alu_op_t;

endpackage

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with illegal-opcode and memory-timeout traps and a retired-instruction counter.
module multicycle_control_unit
    import alu_op_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 IorD,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 Branch,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemtoReg,
    output logic                 ALUSrc,
    output alu_op_t              ALUOp,
    output logic                 RegWrite,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ClsLoad  = 3'd0,
        ClsStore = 3'd1,
        ClsBranch = 3'd2,
        ClsOp    = 3'd3,
        ClsOpImm = 3'd4
    } cls_e;

    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = (MEM_TIMEOUT > 0) ? WaitW'(MEM_TIMEOUT - 1) : '0;

    state_e               state_q, state_d;
    cls_e                 cls_q, cls_d;
    alu_op_t              alu_op_q, alu_op_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic                 illegal_q, illegal_d;
    logic                 bus_err_q, bus_err_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       dec_ok;
    cls_e       dec_cls;
    alu_op_t    dec_alu;
    alu_op_t    f3_alu;
    logic       timeout;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};
    // Last permitted wait cycle; a ready in this same cycle still completes normally.
    assign timeout      = (MEM_TIMEOUT != 0) && (wait_q == WaitLast) && !mem_ready;

    always_comb begin
        f3_alu = AluAdd;
        unique case (funct3)
            3'b000: f3_alu = AluAdd;
            3'b001: f3_alu = AluSll;
            3'b010: f3_alu = AluSlt;
            3'b011: f3_alu = AluSltu;
            3'b100: f3_alu = AluXor;
            3'b101: f3_alu = (funct7 == 7'h20) ? AluSra : AluSrl;
            3'b110: f3_alu = AluOr;
            3'b111: f3_alu = AluAnd;
            default: f3_alu = AluAdd;
        endcase
    end

    always_comb begin
        dec_ok  = 1'b1;
        dec_cls = ClsOp;
        dec_alu = AluAdd;
        case (opcode)
            7'b0000011: dec_cls = ClsLoad;
            7'b0100011: dec_cls = ClsStore;
            7'b1100011: begin
                dec_cls = ClsBranch;
                dec_alu = AluSub;
            end
            7'b0110011: begin
                dec_cls = ClsOp;
                dec_alu = (funct3 == 3'b000 && funct7 == 7'h20) ? AluSub : f3_alu;
                dec_ok  = (funct7 == 7'h00) ||
                          (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            7'b0010011: begin
                dec_cls = ClsOpImm;
                dec_alu = f3_alu;
                if (funct3 == 3'b001) begin
                    dec_ok = (funct7 == 7'h00);
                end else if (funct3 == 3'b101) begin
                    dec_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
                end
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_op_d  = alu_op_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        instret_d = instret_q;
        mem_req   = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        Branch    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrc    = 1'b0;
        ALUOp     = AluAdd;
        RegWrite  = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = StTrap;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                if (dec_ok) begin
                    cls_d    = dec_cls;
                    alu_op_d = dec_alu;
                    state_d  = StExec;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end
            end
            StExec: begin
                ALUOp  = alu_op_q;
                ALUSrc = (cls_q == ClsLoad) || (cls_q == ClsStore) || (cls_q == ClsOpImm);
                case (cls_q)
                    ClsBranch: begin
                        Branch    = 1'b1;
                        instret_d = instret_q + INSTRET_W'(1);
                        state_d   = StFetch;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    default:           state_d = StWb;
                endcase
            end
            StMem: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                ALUSrc   = 1'b1;
                MemRead  = (cls_q == ClsLoad);
                MemWrite = (cls_q == ClsStore);
                if (mem_ready) begin
                    if (cls_q == ClsLoad) begin
                        state_d = StWb;
                    end else begin
                        instret_d = instret_q + INSTRET_W'(1);
                        state_d   = StFetch;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = StTrap;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWb: begin
                RegWrite  = 1'b1;
                MemtoReg  = (cls_q == ClsLoad);
                instret_d = instret_q + INSTRET_W'(1);
                state_d   = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase

        // Keep every strobe low while reset is asserted, even though the state reads FETCH.
        if (!rst_n) begin
            mem_req  = 1'b0;
            IorD     = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            Branch   = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            MemtoReg = 1'b0;
            ALUSrc   = 1'b0;
            ALUOp    = AluAdd;
            RegWrite = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            cls_q     <= ClsLoad;
            alu_op_q  <= AluAdd;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_op_q  <= alu_op_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;
    assign instret = instret_q;

endmodule
